// File: rtl/stepper_multi_axis.sv
// stepper_multi_axis: NUM_CH independent 4-wire bipolar stepper channels behind
// one Avalon-MM slave. Each channel has a CTRL/DIV/STEPS/STATUS register set,
// a step-period divider, a move counter and a registered coil driver.
// Optional build macro STEPPER_POS_EN adds a signed per-channel position
// counter at register 4; without it register 4 reads 0 and ignores writes.
module stepper_multi_axis #(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 24,
    parameter int COUNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(NUM_CH)+2:0] address,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic                      irq,
    output logic [4*NUM_CH-1:0]       coils
);
    localparam int AW = $clog2(NUM_CH) + 3;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_DIV    = 3'd1;
    localparam logic [2:0] REG_STEPS  = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_POS    = 3'd4;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    // Phase index -> {A+,A-,B+,B-}; even indices are single-coil, odd are two-coil.
    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1010;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0100;
            3'd5:    return 4'b0101;
            3'd6:    return 4'b0001;
            default: return 4'b1001;
        endcase
    endfunction

    logic [2:0]        reg_sel;
    logic              wr_any;
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] irq_vec;
    logic [31:0]       rd_val [NUM_CH];
    logic [31:0]       rd_mux;
    logic [31:0]       readdata_q;

    assign reg_sel = address[2:0];
    assign wr_any  = chipselect & write;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e             state_q, state_d;
        logic               enable_q, enable_d;
        logic               dir_q, dir_d;
        logic               half_q, half_d;
        logic               irq_en_q, irq_en_d;
        logic               done_q, done_d;
        logic [DIV_W-1:0]   div_q, div_d;
        logic [DIV_W-1:0]   tick_q, tick_d;
        logic [DIV_W-1:0]   period_m1;
        logic [COUNT_W-1:0] remaining_q, remaining_d;
        logic [COUNT_W-1:0] wr_count;
        logic [2:0]         index_q, index_d;
        logic [2:0]         step_amt;
        logic [3:0]         coils_q, coils_d;
        logic               wr_ch, step_due, abort, load;
        logic [31:0]        rd_val_c;
`ifdef STEPPER_POS_EN
        logic signed [COUNT_W-1:0] pos_q, pos_d;
`endif

        assign ch_hit[c] = ((address >> 3) == AW'(c));
        assign wr_ch     = wr_any & ch_hit[c];
        assign wr_count  = writedata[COUNT_W-1:0];
        // DIV of 0 behaves like 1: one step per cycle.
        assign period_m1 = (div_q == '0) ? '0 : div_q - DIV_W'(1);
        assign step_amt  = half_q ? 3'd1 : 3'd2;

        // Next state: register writes, move load/abort and step sequencing.
        always_comb begin
            // NOTE: every signal assigned here gets a default first, so no latch is inferred.
            state_d     = state_q;
            enable_d    = enable_q;
            dir_d       = dir_q;
            half_d      = half_q;
            irq_en_d    = irq_en_q;
            done_d      = done_q;
            div_d       = div_q;
            tick_d      = tick_q;
            remaining_d = remaining_q;
            index_d     = index_q;
`ifdef STEPPER_POS_EN
            pos_d       = pos_q;
`endif
            // ">=" so a DIV shrunk below the running tick steps on the next cycle.
            step_due = (state_q == ST_RUN) && (tick_q >= period_m1);
            abort    = wr_ch && (((reg_sel == REG_CTRL) && (writedata[4] || !writedata[0])) ||
                                 ((reg_sel == REG_STEPS) && (wr_count == '0) && (state_q == ST_RUN)));
            load     = wr_ch && (reg_sel == REG_STEPS) && (wr_count != '0) && enable_q;

            if (wr_ch && (reg_sel == REG_CTRL)) begin
                {irq_en_d, half_d, dir_d, enable_d} = writedata[3:0];
            end
            if (wr_ch && (reg_sel == REG_DIV)) begin
                div_d = writedata[DIV_W-1:0];
            end
            // Clear first so a step completing in the same cycle re-sets done.
            if (wr_ch && (reg_sel == REG_STATUS) && writedata[0]) begin
                done_d = 1'b0;
            end
            if (state_q == ST_RUN) begin
                tick_d = tick_q + DIV_W'(1);
            end

            // Priority: abort, then a new load, then the step itself.
            if (abort) begin
                state_d     = ST_IDLE;
                remaining_d = '0;
                tick_d      = '0;
            end else if (load) begin
                state_d     = ST_RUN;
                remaining_d = wr_count;
                tick_d      = '0;
            end else if (step_due) begin
                tick_d      = '0;
                index_d     = dir_q ? index_q + step_amt : index_q - step_amt;
                remaining_d = remaining_q - COUNT_W'(1);
`ifdef STEPPER_POS_EN
                pos_d       = dir_q ? pos_q + COUNT_W'(1) : pos_q - COUNT_W'(1);
`endif
                if (remaining_q == COUNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

`ifdef STEPPER_POS_EN
            // A position load overrides a step in the same cycle.
            if (wr_ch && (reg_sel == REG_POS)) begin
                pos_d = wr_count;
            end
`endif
        end

        // State and datapath registers with synchronous active-high reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q     <= ST_IDLE;
                enable_q    <= 1'b0;
                dir_q       <= 1'b0;
                half_q      <= 1'b0;
                irq_en_q    <= 1'b0;
                done_q      <= 1'b0;
                div_q       <= '0;
                tick_q      <= '0;
                remaining_q <= '0;
                index_q     <= '0;
                coils_q     <= '0;
`ifdef STEPPER_POS_EN
                pos_q       <= '0;
`endif
            end else begin
                // NOTE: non-blocking so every register samples pre-edge values.
                state_q     <= state_d;
                enable_q    <= enable_d;
                dir_q       <= dir_d;
                half_q      <= half_d;
                irq_en_q    <= irq_en_d;
                done_q      <= done_d;
                div_q       <= div_d;
                tick_q      <= tick_d;
                remaining_q <= remaining_d;
                index_q     <= index_d;
                coils_q     <= coils_d;
`ifdef STEPPER_POS_EN
                pos_q       <= pos_d;
`endif
            end
        end

        // Outputs: next coil pattern and this channel's read value.
        always_comb begin
            coils_d  = enable_q ? phase_pattern(index_q) : 4'b0000;
            rd_val_c = '0;
            case (reg_sel)
                REG_CTRL:   rd_val_c = {28'd0, irq_en_q, half_q, dir_q, enable_q};
                REG_DIV:    rd_val_c = 32'(div_q);
                REG_STEPS:  rd_val_c = 32'(remaining_q);
                REG_STATUS: rd_val_c = {27'd0, index_q, (state_q == ST_RUN), done_q};
`ifdef STEPPER_POS_EN
                REG_POS:    rd_val_c = 32'(pos_q);
`endif
                default:    rd_val_c = '0;
            endcase
        end

        assign rd_val[c]         = rd_val_c;
        assign irq_vec[c]        = done_q & irq_en_q;
        assign coils[4*c +: 4]   = coils_q;
    end

    // Read mux: addressed channel's value, zero for unmapped channel codes.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_hit[c]) rd_mux = rd_val[c];
        end
    end

    // Registered read data, fixed one-cycle latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (chipselect && read) begin
            readdata_q <= rd_mux;
        end else begin
            readdata_q <= '0;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |irq_vec;

endmodule
